pcm_downlink_capture: RTL and testbench

//  Downstream consumer of the AGC telemetry downlink. Watches the DKSTRT/DKBSNC/DKEND

---
 rtl/pcm_downlink_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_pcm_downlink_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pcm_downlink_capture.sv
// Captures AGC telemetry downlink frames (DKSTRT/DKBSNC/DKEND framing, DKDATA MSB first)
// into WORD_BITS-wide words, buffers them in a FWFT FIFO and keeps frame statistics.
module pcm_downlink_capture #(
    parameter int WORD_BITS  = 40,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dkstrt,
    input  logic                 dkbsnc,
    input  logic                 dkend,
    input  logic                 dkdata,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_status,
    output logic                 overflow,
    output logic [15:0]          good_count,
    output logic [15:0]          err_count,
    output logic                 busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_BITS + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_BITS + 1);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    logic [2:0] strt_q, bsnc_q, end_q;
    logic [1:0] data_q;
    logic       strt_rise_s, bsnc_rise_s, end_rise_s, data_s;

    state_t                state_q, state_d;
    logic [WORD_BITS-1:0]  sr_q, sr_d, sr_shift_s;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_upd_s;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  push_s, good_inc_s, err_inc_s;

    logic [WORD_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         rd_addr_next_s;
    logic                  full_s, empty_s, pop_s, wr_en_s, drop_s;
    logic [WORD_BITS-1:0]  head_next_s, out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, busy_q;
    logic [15:0]           good_q, err_q;

    // Input synchronizers; the third flop of each strobe provides the rising-edge reference
    always_ff @(posedge clk) begin
        if (rst) begin
            strt_q <= 3'b000;
            bsnc_q <= 3'b000;
            end_q  <= 3'b000;
            data_q <= 2'b00;
        end else begin
            strt_q <= {strt_q[1:0], dkstrt};
            bsnc_q <= {bsnc_q[1:0], dkbsnc};
            end_q  <= {end_q[1:0], dkend};
            data_q <= {data_q[0], dkdata};
        end
    end

    assign strt_rise_s = strt_q[1] & ~strt_q[2];
    assign bsnc_rise_s = bsnc_q[1] & ~bsnc_q[2];
    assign end_rise_s  = end_q[1] & ~end_q[2];
    assign data_s      = data_q[1];

    // Frame FSM next-state: shift first, then end, restart and timeout in priority order
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        sr_shift_s = sr_q;
        cnt_upd_s  = cnt_q;
        push_s     = 1'b0;
        good_inc_s = 1'b0;
        err_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strt_rise_s) begin
                    state_d = ST_SHIFT;
                    sr_d    = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bsnc_rise_s) begin
                    sr_shift_s = {sr_q[WORD_BITS-2:0], data_s};
                    cnt_upd_s  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    sr_shift_s = sr_q;
                    cnt_upd_s  = cnt_q;
                end
                sr_d  = sr_shift_s;
                cnt_d = cnt_upd_s;
                if (strt_rise_s || bsnc_rise_s || end_rise_s) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (end_rise_s) begin
                    if (cnt_upd_s == CNT_FULL) begin
                        good_inc_s = 1'b1;
                        push_s     = 1'b1;
                    end else begin
                        err_inc_s = 1'b1;
                    end
                    if (strt_rise_s) begin
                        sr_d  = '0;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (strt_rise_s) begin
                    err_inc_s = 1'b1;
                    sr_d      = '0;
                    cnt_d     = '0;
                end else if (!bsnc_rise_s && timer_q == TMO) begin
                    err_inc_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state, shift register, bit counter and inactivity timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // FIFO control; the new head bypasses memory when it is written this very cycle
    always_comb begin
        full_s         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s        = (wr_ptr_q == rd_ptr_q);
        pop_s          = !empty_s && out_ready;
        wr_en_s        = push_s && (!full_s || pop_s);
        drop_s         = push_s && full_s && !pop_s;
        wr_ptr_d       = wr_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_addr_next_s = rd_ptr_d[AW-1:0];
        if (wr_en_s && (wr_ptr_q[AW-1:0] == rd_addr_next_s)) begin
            head_next_s = sr_shift_s;
        end else begin
            head_next_s = mem_q[rd_addr_next_s];
        end
        out_valid_d = (wr_ptr_d != rd_ptr_d);
        out_data_d  = out_valid_d ? head_next_s : out_data_q;
    end

    // FIFO storage, pointers and registered head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= sr_shift_s;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Statistics: saturating counters and sticky overflow, clear has priority
    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            good_q     <= 16'h0000;
            err_q      <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            if (good_inc_s && good_q != 16'hFFFF) begin
                good_q <= good_q + 16'd1;
            end
            if (err_inc_s && err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign good_count = good_q;
    assign err_count  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pcm_downlink_capture.sv
// Directed self-checking bench for pcm_downlink_capture (FIFO_DEPTH=4, TIMEOUT=100).
module tb_pcm_downlink_capture;

    logic        clk = 1'b0;
    logic        rst, dkstrt, dkbsnc, dkend, dkdata, out_ready, clr_status;
    logic [39:0] out_data;
    logic        out_valid, overflow, busy;
    logic [15:0] good_count, err_count;

    int total  = 0;
    int passed = 0;

    logic [39:0] f3 [5];

    pcm_downlink_capture #(.WORD_BITS(40), .FIFO_DEPTH(4), .TIMEOUT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .dkstrt     (dkstrt),
        .dkbsnc     (dkbsnc),
        .dkend      (dkend),
        .dkdata     (dkdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_status (clr_status),
        .overflow   (overflow),
        .good_count (good_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [39:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            dkdata = w[39-i];
            tick(2);
            dkbsnc = 1'b1;
            tick(4);
            dkbsnc = 1'b0;
            tick(3);
        end
    endtask

    task automatic strobe(input logic s, input logic e);
        dkstrt = s;
        dkend  = e;
        tick(4);
        dkstrt = 1'b0;
        dkend  = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input logic [39:0] w);
        strobe(1'b1, 1'b0);
        send_bits(w, 40);
        strobe(1'b0, 1'b1);
        tick(3);
    endtask

    task automatic pop_check(input string tag, input logic [39:0] exp);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
    endtask

    task automatic clear_stats();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        tick(1);
    endtask

    initial begin
        f3[0] = 40'h1111111111;
        f3[1] = 40'h2222222222;
        f3[2] = 40'h3333333333;
        f3[3] = 40'h4444444444;
        f3[4] = 40'h5555555555;
        rst = 1'b1; dkstrt = 1'b0; dkbsnc = 1'b0; dkend = 1'b0; dkdata = 1'b0;
        out_ready = 1'b0; clr_status = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", {24'd0, out_data}, 64'd0);
        check("rst_good", {48'd0, good_count}, 64'd0);
        check("rst_err", {48'd0, err_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);

        // 1. Good frame
        send_frame(40'hA55A0FF0C3);
        check("t1_good", {48'd0, good_count}, 64'd1);
        check("t1_err", {48'd0, err_count}, 64'd0);
        check("t1_busy", {63'd0, busy}, 64'd0);
        pop_check("t1_pop", 40'hA55A0FF0C3);
        check("t1_empty", {63'd0, out_valid}, 64'd0);
        check("t1_hold", {24'd0, out_data}, 64'h000000A55A0FF0C3);

        // 2. Short frame
        strobe(1'b1, 1'b0);
        send_bits(40'hFFFFFFFFFF, 39);
        strobe(1'b0, 1'b1);
        tick(3);
        check("t2_valid", {63'd0, out_valid}, 64'd0);
        check("t2_err", {48'd0, err_count}, 64'd1);
        check("t2_good", {48'd0, good_count}, 64'd1);
        clear_stats();
        check("clr_good", {48'd0, good_count}, 64'd0);
        check("clr_err", {48'd0, err_count}, 64'd0);

        // 3. Overflow with a 4-deep FIFO
        for (int k = 0; k < 5; k++) send_frame(f3[k]);
        check("t3_ovf", {63'd0, overflow}, 64'd1);
        check("t3_good", {48'd0, good_count}, 64'd5);
        for (int k = 0; k < 4; k++) pop_check("t3_pop", f3[k]);
        check("t3_empty", {63'd0, out_valid}, 64'd0);
        clear_stats();
        check("t3_ovf_clr", {63'd0, overflow}, 64'd0);

        // 4. Restart mid-frame
        strobe(1'b1, 1'b0);
        send_bits(40'hFFFFFFFFFF, 10);
        send_frame(40'h0123456789);
        check("t4_err", {48'd0, err_count}, 64'd1);
        check("t4_good", {48'd0, good_count}, 64'd1);
        pop_check("t4_pop", 40'h0123456789);
        check("t4_empty", {63'd0, out_valid}, 64'd0);
        clear_stats();

        // 5. Timeout
        strobe(1'b1, 1'b0);
        send_bits(40'hFFFFFFFFFF, 5);
        tick(50);
        check("t5_busy_mid", {63'd0, busy}, 64'd1);
        tick(70);
        check("t5_busy", {63'd0, busy}, 64'd0);
        check("t5_err", {48'd0, err_count}, 64'd1);
        send_frame(40'h00DEADBEEF);
        check("t5_good", {48'd0, good_count}, 64'd1);
        pop_check("t5_pop", 40'h00DEADBEEF);
        clear_stats();

        // 6. Reset mid-frame, then simultaneous start+end
        strobe(1'b1, 1'b0);
        send_bits(40'h0F0F0F0F0F, 20);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        send_frame(40'hFFFFFFFFFF);
        check("t6_good", {48'd0, good_count}, 64'd1);
        check("t6_err", {48'd0, err_count}, 64'd0);
        pop_check("t6_pop", 40'hFFFFFFFFFF);
        check("t6_empty", {63'd0, out_valid}, 64'd0);
        strobe(1'b1, 1'b0);
        send_bits(40'h13579BDF02, 40);
        strobe(1'b1, 1'b1);
        check("t6_se_good", {48'd0, good_count}, 64'd2);
        check("t6_se_busy", {63'd0, busy}, 64'd1);
        send_bits(40'h2468ACE013, 40);
        strobe(1'b0, 1'b1);
        tick(3);
        check("t6_se_good2", {48'd0, good_count}, 64'd3);
        check("t6_se_err", {48'd0, err_count}, 64'd0);
        check("t6_se_idle", {63'd0, busy}, 64'd0);
        pop_check("t6_se_pop1", 40'h13579BDF02);
        pop_check("t6_se_pop2", 40'h2468ACE013);
        check("t6_se_empty", {63'd0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
